cluster_periph_initiator: RTL

CLUSTER_PERIPH_INITIATOR -- requirements
Module: cluster_periph_initiator

---
 rtl/cluster_periph_initiator.sv | 133 +++++++++++++
 1 files changed

// File: rtl/cluster_periph_initiator.sv
// Single-outstanding bus initiator: turns one command into a peripheral req/gnt + r_valid
// transaction and returns the result on a rsp handshake, aborting after TIMEOUT_CYCLES.
//
// state  | meaning
// IDLE   | ready for a command (cmd_ready_o = 1)
// REQ    | periph_req_o held with the latched command until grant
// WAIT_R | granted, waiting for r_valid carrying MASTER_ID
// RESP   | rsp_valid_o held until rsp_ready_i
module cluster_periph_initiator #(
  parameter int unsigned PER_ID_WIDTH   = 5,
  parameter int unsigned MASTER_ID      = 0,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_we_i,
  input  logic [31:0]             cmd_addr_i,
  input  logic [31:0]             cmd_wdata_i,
  input  logic [3:0]              cmd_be_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [31:0]             rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_timeout_o,
  output logic                    periph_req_o,
  input  logic                    periph_gnt_i,
  output logic [31:0]             periph_add_o,
  output logic [31:0]             periph_wdata_o,
  output logic [3:0]              periph_be_o,
  output logic                    periph_wen_o,
  output logic [PER_ID_WIDTH-1:0] periph_id_o,
  input  logic                    periph_r_valid_i,
  input  logic                    periph_r_opc_i,
  input  logic [PER_ID_WIDTH-1:0] periph_r_id_i,
  input  logic [31:0]             periph_r_rdata_i,
  output logic                    busy_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PER_ID_WIDTH-1:0] OWN_ID = PER_ID_WIDTH'(MASTER_ID);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             we_q;
  logic             rsp_match;
  logic             expire;

  assign periph_id_o  = OWN_ID;
  assign periph_wen_o = ~we_q;
  assign rsp_match    = periph_r_valid_i && (periph_r_id_i == OWN_ID);
  // ">=" rather than "==": a grant won on the last cycle leaves WAIT_R already past the limit
  assign expire       = (TIMEOUT_CYCLES != 0) && (cnt_q >= CNT_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      we_q           <= 1'b0;
      periph_add_o   <= '0;
      periph_wdata_o <= '0;
      periph_be_o    <= '0;
      periph_req_o   <= 1'b0;
      cmd_ready_o    <= 1'b0;
      busy_o         <= 1'b0;
      rsp_valid_o    <= 1'b0;
      rsp_rdata_o    <= '0;
      rsp_err_o      <= 1'b0;
      rsp_timeout_o  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cmd_ready_o <= 1'b1;
          if (cmd_valid_i && cmd_ready_o) begin
            we_q           <= cmd_we_i;
            periph_add_o   <= cmd_addr_i;
            periph_wdata_o <= cmd_wdata_i;
            periph_be_o    <= cmd_be_i;
            cnt_q          <= '0;
            periph_req_o   <= 1'b1;
            cmd_ready_o    <= 1'b0;
            busy_o         <= 1'b1;
            state_q        <= REQ;
          end
        end
        REQ: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (periph_gnt_i) begin
            periph_req_o <= 1'b0;
            state_q      <= WAIT_R;
          end else if (expire) begin
            periph_req_o  <= 1'b0;
            rsp_valid_o   <= 1'b1;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b1;
            rsp_timeout_o <= 1'b1;
            state_q       <= RESP;
          end
        end
        WAIT_R: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (rsp_match) begin
            rsp_valid_o   <= 1'b1;
            rsp_rdata_o   <= periph_r_rdata_i;
            rsp_err_o     <= periph_r_opc_i;
            rsp_timeout_o <= 1'b0;
            state_q       <= RESP;
          end else if (expire) begin
            rsp_valid_o   <= 1'b1;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b1;
            rsp_timeout_o <= 1'b1;
            state_q       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
